// File: rtl/run_context_bank.sv
// ---------------------------------------------------------------------------
// run_context_bank
//
// Context store and updater for JPEG-LS run-interruption coding. Holds
// NUM_CTX contexts of {A, Nn, N}, serves registered reads, and applies the
// per-sample update (accumulate, halve at RESET_THR, increment N). A clr
// pulse sweeps every context back to its initial value, one entry per cycle.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      asynchronous reset, active low
//   i_clr        one-cycle pulse starting a re-initialisation sweep
//   o_busy       high while the sweep runs (reads/updates are ignored)
//   i_rd_en      read request
//   i_rd_idx     context to read
//   o_rd_valid   read data valid, one cycle after an accepted request
//   o_a_out      A of the read context
//   o_nn_out     Nn of the read context
//   o_n_out      N of the read context
//   i_upd_en     update request
//   i_upd_idx    context to update
//   i_upd_inc    A increment from the error mapper
//   i_upd_neg    1 when the error was negative
// ---------------------------------------------------------------------------
module run_context_bank #(
    parameter int NUM_CTX   = 2,
    parameter int IDX_W     = 1,
    parameter int A_W       = 13,
    parameter int N_W       = 7,
    parameter int RESET_THR = 64,
    parameter int A_INIT    = 4,
    parameter int N_INIT    = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    output logic             o_busy,
    input  logic             i_rd_en,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_valid,
    output logic [A_W-1:0]   o_a_out,
    output logic [N_W-1:0]   o_nn_out,
    output logic [N_W-1:0]   o_n_out,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic [A_W-1:0]   i_upd_inc,
    input  logic             i_upd_neg
);

    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_CTX - 1);

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_k, w_k_next;

    logic [A_W-1:0] r_a  [NUM_CTX];
    logic [N_W-1:0] r_nn [NUM_CTX];
    logic [N_W-1:0] r_n  [NUM_CTX];

    logic           r_rd_valid;
    logic [A_W-1:0] r_a_out;
    logic [N_W-1:0] r_nn_out, r_n_out;

    logic           w_busy, w_idle_go, w_rd_go, w_upd_hit, w_upd_go, w_halve;
    logic [A_W-1:0] w_cur_a, w_new_a, w_rd_a;
    logic [N_W-1:0] w_cur_nn, w_cur_n, w_new_nn, w_new_n, w_rd_nn, w_rd_n;
    logic [A_W:0]   w_sum_a, w_scaled_a;
    logic [N_W:0]   w_sum_nn, w_scaled_nn;

    // ------------------------------------------------------------------
    // Clear FSM: state register plus next-state logic
    // ------------------------------------------------------------------
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
        end
    end

    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        case (r_state)
            ST_IDLE: begin
                if (i_clr) begin
                    w_state_next = ST_SWEEP;
                    w_k_next     = '0;
                end
            end
            ST_SWEEP: begin
                if (i_clr) begin
                    w_k_next = '0;              // restart the sweep
                end else if (r_k == K_LAST) begin
                    w_state_next = ST_IDLE;
                    w_k_next     = '0;
                end else begin
                    w_k_next = r_k + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_k_next     = '0;
            end
        endcase
    end

    assign w_busy    = (r_state == ST_SWEEP);
    // clr wins over a read/update presented in the same IDLE cycle
    assign w_idle_go = !w_busy && !i_clr;
    assign w_rd_go   = i_rd_en && w_idle_go;
    assign w_upd_go  = i_upd_en && w_idle_go && w_upd_hit;

    // ------------------------------------------------------------------
    // Update datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_upd_hit = 1'b0;
        w_cur_a   = '0;
        w_cur_nn  = '0;
        w_cur_n   = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (i_upd_idx == IDX_W'(i)) begin
                w_upd_hit = 1'b1;
                w_cur_a   = r_a[i];
                w_cur_nn  = r_nn[i];
                w_cur_n   = r_n[i];
            end
        end
    end

    assign w_sum_a     = {1'b0, w_cur_a} + {1'b0, i_upd_inc};
    assign w_sum_nn    = {1'b0, w_cur_nn} + {{N_W{1'b0}}, i_upd_neg};
    assign w_halve     = (w_cur_n == N_W'(RESET_THR));
    assign w_scaled_a  = w_halve ? (w_sum_a >> 1) : w_sum_a;
    assign w_scaled_nn = w_halve ? (w_sum_nn >> 1) : w_sum_nn;
    assign w_new_n     = w_halve ? ((w_cur_n >> 1) + 1'b1) : (w_cur_n + 1'b1);
    // Carry out of A means overflow; clamp to all ones instead of wrapping.
    assign w_new_a     = w_scaled_a[A_W] ? '1 : w_scaled_a[A_W-1:0];
    // Nn is a count of negative errors and can never exceed the sample count.
    assign w_new_nn    = (w_scaled_nn > {1'b0, w_new_n}) ? w_new_n
                                                          : w_scaled_nn[N_W-1:0];

    // ------------------------------------------------------------------
    // Read mux with same-cycle forwarding of the update result
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_a  = '0;
        w_rd_nn = '0;
        w_rd_n  = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (i_rd_idx == IDX_W'(i)) begin
                if (w_upd_go && (i_upd_idx == i_rd_idx)) begin
                    w_rd_a  = w_new_a;
                    w_rd_nn = w_new_nn;
                    w_rd_n  = w_new_n;
                end else begin
                    w_rd_a  = r_a[i];
                    w_rd_nn = r_nn[i];
                    w_rd_n  = r_n[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Context storage
    // ------------------------------------------------------------------
    // NOTE: the contexts are plain flops with defined reset values, so the
    // whole array is reset; a RAM-style array would be left unreset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                r_a[i]  <= A_W'(A_INIT);
                r_nn[i] <= '0;
                r_n[i]  <= N_W'(N_INIT);
            end
        end else begin
            for (int i = 0; i < NUM_CTX; i++) begin
                if (w_busy && (r_k == IDX_W'(i))) begin
                    r_a[i]  <= A_W'(A_INIT);
                    r_nn[i] <= '0;
                    r_n[i]  <= N_W'(N_INIT);
                end else if (w_upd_go && (i_upd_idx == IDX_W'(i))) begin
                    r_a[i]  <= w_new_a;
                    r_nn[i] <= w_new_nn;
                    r_n[i]  <= w_new_n;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered read port; data holds when no read is accepted
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_valid <= 1'b0;
            r_a_out    <= A_W'(A_INIT);
            r_nn_out   <= '0;
            r_n_out    <= N_W'(N_INIT);
        end else begin
            r_rd_valid <= w_rd_go;
            if (w_rd_go) begin
                r_a_out  <= w_rd_a;
                r_nn_out <= w_rd_nn;
                r_n_out  <= w_rd_n;
            end
        end
    end

    assign o_busy     = w_busy;
    assign o_rd_valid = r_rd_valid;
    assign o_a_out    = r_a_out;
    assign o_nn_out   = r_nn_out;
    assign o_n_out    = r_n_out;

endmodule

// File: tb/tb_run_context_bank.sv
// ---------------------------------------------------------------------------
// tb_run_context_bank
//
// Directed bench for run_context_bank with three contexts (so index 3 is out
// of range). Expected read results are queued when a read is issued and
// compared when the DUT raises rd_valid; other points are checked inline.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_run_context_bank;

    localparam int NUM_CTX = 3;
    localparam int IDX_W   = 2;
    localparam int A_W     = 13;
    localparam int N_W     = 7;

    typedef struct {
        int a;
        int nn;
        int n;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             busy;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid;
    logic [A_W-1:0]   a_out;
    logic [N_W-1:0]   nn_out;
    logic [N_W-1:0]   n_out;
    logic             upd_en;
    logic [IDX_W-1:0] upd_idx;
    logic [A_W-1:0]   upd_inc;
    logic             upd_neg;

    exp_t exp_q[$];
    exp_t pend;
    bit   pend_valid;
    int   n_pass;
    int   n_total;
    int   rd_seq;

    run_context_bank #(
        .NUM_CTX  (NUM_CTX),
        .IDX_W    (IDX_W),
        .A_W      (A_W),
        .N_W      (N_W),
        .RESET_THR(64),
        .A_INIT   (4),
        .N_INIT   (1)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_clr     (clr),
        .o_busy    (busy),
        .i_rd_en   (rd_en),
        .i_rd_idx  (rd_idx),
        .o_rd_valid(rd_valid),
        .o_a_out   (a_out),
        .o_nn_out  (nn_out),
        .o_n_out   (n_out),
        .i_upd_en  (upd_en),
        .i_upd_idx (upd_idx),
        .i_upd_inc (upd_inc),
        .i_upd_neg (upd_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // One clock edge with the currently driven inputs; strobes drop after it.
    task automatic step();
        @(posedge clk);
        if (pend_valid) begin
            exp_q.push_back(pend);
            pend_valid = 1'b0;
        end
        #1;
        rd_en  = 1'b0;
        upd_en = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic set_rd(input int idx, input int a, input int nn, input int n);
        rd_en      = 1'b1;
        rd_idx     = IDX_W'(idx);
        pend       = '{a, nn, n};
        pend_valid = 1'b1;
    endtask

    task automatic set_upd(input int idx, input int inc, input bit neg);
        upd_en  = 1'b1;
        upd_idx = IDX_W'(idx);
        upd_inc = A_W'(inc);
        upd_neg = neg;
    endtask

    task automatic rd(input int idx, input int a, input int nn, input int n);
        set_rd(idx, a, nn, n);
        step();
    endtask

    task automatic upd(input int idx, input int inc, input bit neg);
        set_upd(idx, inc, neg);
        step();
    endtask

    // Scoreboard side: every queued read must come back exactly one edge later.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                rd_seq++;
                check($sformatf("rd%0d_a", rd_seq), 32'(a_out), 32'(e.a));
                check($sformatf("rd%0d_nn", rd_seq), 32'(nn_out), 32'(e.nn));
                check($sformatf("rd%0d_n", rd_seq), 32'(n_out), 32'(e.n));
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            rd_seq++;
            check($sformatf("rd%0d_valid_missing", rd_seq), 32'(rd_valid), 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_len;
        n_pass     = 0;
        n_total    = 0;
        rd_seq     = 0;
        pend_valid = 1'b0;
        rst_n      = 1'b0;
        clr        = 1'b0;
        rd_en      = 1'b0;
        rd_idx     = '0;
        upd_en     = 1'b0;
        upd_idx    = '0;
        upd_inc    = '0;
        upd_neg    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 32'(a_out), 32'd4);
        check("reset_nn", 32'(nn_out), 32'd0);
        check("reset_n", 32'(n_out), 32'd1);
        check("reset_valid", 32'(rd_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Out-of-range read, then back-to-back reads of every context
        rd(3, 0, 0, 0);
        rd(0, 4, 0, 1);
        rd(1, 4, 0, 1);
        rd(2, 4, 0, 1);
        step();
        check("hold_a", 32'(a_out), 32'd4);
        check("hold_n", 32'(n_out), 32'd1);
        check("hold_valid", 32'(rd_valid), 32'd0);

        // Plain update, neighbour untouched
        upd(0, 3, 1'b1);
        rd(0, 7, 1, 2);
        rd(1, 4, 0, 1);

        // Walk N up to the threshold, then the halving update
        for (int i = 0; i < 63; i++) upd(1, 0, 1'b0);
        rd(1, 4, 0, 64);
        upd(1, 2, 1'b1);
        rd(1, 3, 0, 33);

        // Same-cycle read and update of one index returns post-update values
        set_upd(2, 5, 1'b0);
        set_rd(2, 9, 0, 2);
        step();
        rd(2, 9, 0, 2);

        // A saturates instead of wrapping
        for (int i = 0; i < 3; i++) upd(0, 8191, 1'b0);
        rd(0, 8191, 1, 5);

        // Read and update of different indices in one cycle
        set_upd(2, 1, 1'b1);
        set_rd(0, 8191, 1, 5);
        step();
        rd(2, 10, 1, 3);

        // Out-of-range update is dropped
        upd(3, 5, 1'b1);
        rd(0, 8191, 1, 5);
        rd(1, 3, 0, 33);
        rd(2, 10, 1, 3);

        // clr with a read and update in the same cycle: both dropped
        clr     = 1'b1;
        rd_en   = 1'b1;
        rd_idx  = 2'd1;
        set_upd(1, 100, 1'b1);
        step();
        // Busy for NUM_CTX cycles; requests meanwhile are ignored
        for (int i = 0; i < NUM_CTX; i++) begin
            check($sformatf("sweep_busy%0d", i), 32'(busy), 32'd1);
            rd_en  = 1'b1;
            rd_idx = 2'd0;
            set_upd(0, 1, 1'b1);
            step();
        end
        check("sweep_done", 32'(busy), 32'd0);
        rd(0, 4, 0, 1);
        rd(1, 4, 0, 1);
        rd(2, 4, 0, 1);

        // clr during a sweep restarts it from entry 0
        upd(1, 7, 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b1;
        step();
        busy_len = 0;
        while (busy && busy_len < 20) begin
            busy_len++;
            step();
        end
        check("restart_busy_len", 32'(busy_len), 32'(NUM_CTX));
        rd(1, 4, 0, 1);

        // Reset in the middle of a sweep aborts it and initialises everything
        upd(2, 5, 1'b0);
        rd(2, 9, 0, 2);
        clr = 1'b1;
        step();
        step();
        check("midsweep_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midsweep_busy", 32'(busy), 32'd0);
        check("midsweep_a", 32'(a_out), 32'd4);
        check("midsweep_n", 32'(n_out), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("post_reset_busy", 32'(busy), 32'd0);
        rd(0, 4, 0, 1);
        rd(1, 4, 0, 1);
        rd(2, 4, 0, 1);

        step();
        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/run_context_bank.md
# run_context_bank

Parametrised context store and updater for JPEG-LS run-interruption coding. It holds NUM_CTX contexts, each an (A, Nn, N) triple, serves registered reads, and performs the full per-sample update internally: accumulate, halve at RESET_THR, then increment N. It also offers a sequential scan-start clear. It sits between the run-interruption error mapper (which supplies the A increment and the error sign) and the Golomb parameter / map-bit logic (which consumes A, Nn, N).

## Interface
- NUM_CTX, default 2: number of contexts; index 0 = RItype 0, index 1 = RItype 1.
- IDX_W, default 1: index width, at least clog2(NUM_CTX).
- A_W, default 13: width of A.
- N_W, default 7: width of N and Nn; must hold RESET_THR.
- RESET_THR, default 64: N value that triggers halving.
- A_INIT, default 4: initial A.
- N_INIT, default 1: initial N. Initial Nn is always 0.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  one-cycle pulse that starts a re-initialisation sweep of all contexts.
- busy  out  1  high while the sweep runs.
- rd_en  in  1  read request.
- rd_idx  in  IDX_W  context to read.
- rd_valid  out  1  read data valid.
- A_out  out  A_W  A of the read context.
- Nn_out  out  N_W  Nn of the read context.
- N_out  out  N_W  N of the read context.
- upd_en  in  1  update request.
- upd_idx  in  IDX_W  context to update.
- upd_inc  in  A_W  A increment, (EMErrval+1-RItype)>>1, computed upstream.
- upd_neg  in  1  1 when Errval < 0.

## Operation
- Storage: NUM_CTX entries of {A[A_W], Nn[N_W], N[N_W]} held in flops.
- Update, committed at the clock edge when upd_en=1, busy=0 and upd_idx < NUM_CTX:
  - Compute sA = A + upd_inc at A_W+1 bits, and sNn = Nn + upd_neg.
  - If N == RESET_THR: A' = sA>>1, Nn' = sNn>>1, N' = (N>>1)+1.
  - Otherwise: A' = sA, Nn' = sNn, N' = N+1.
  - A' saturates at 2^A_W-1. Nn' saturates at N' (Nn never exceeds N).
- An update with upd_idx >= NUM_CTX is dropped. No other state changes.
- Read: when rd_en=1 and busy=0, the outputs are registered from entry rd_idx.
  - rd_idx >= NUM_CTX returns A=0, Nn=0, N=0, with rd_valid still 1.
- Forwarding: if a read and an update hit the same index in the same cycle, the read returns the post-update values (A', Nn', N').
- Outputs hold their value when no read is accepted. rd_valid is 0 in that case.
- Clear FSM, two states:
  - IDLE -> SWEEP on clr=1.
  - In SWEEP, sweep counter k runs 0..NUM_CTX-1; entry k is written {A_INIT, 0, N_INIT} each cycle.
  - SWEEP -> IDLE after k = NUM_CTX-1.
  - busy = (state == SWEEP).
- A clr arriving in SWEEP restarts k at 0.
- During SWEEP, rd_en and upd_en are ignored: no write, rd_valid = 0. Upstream must stall.
- A clr in the same cycle as rd_en/upd_en in IDLE: clr wins, and the read/update is dropped.

## Timing
- Reset (asynchronous, active-low):
  - Every entry = {A_INIT, 0, N_INIT}.
  - A_out = A_INIT, Nn_out = 0, N_out = N_INIT.
  - rd_valid = 0, busy = 0, state = IDLE, k = 0.
  - No sweep is needed after reset.
- Reset asserted mid-sweep aborts the sweep immediately. All entries initialise and busy = 0.
- Read latency: 1 cycle. rd_en at edge t gives data and rd_valid=1 after edge t+1, for one cycle per request. Back-to-back reads give one result per cycle.
- Update latency: 1 cycle. Its value is visible to a read issued in the same cycle (forwarded) and to any later read.
- Throughput: one read plus one update per cycle, to any indices.
- clr sampled at edge t: busy = 1 from after edge t for exactly NUM_CTX cycles. The first accepted rd_en/upd_en is at the edge where busy has returned to 0.

## Test plan
- Reset, then read index 0 and index 1 -> A=4, Nn=0, N=1, rd_valid one cycle after each rd_en.
- Update index 0 with inc=3, neg=1 -> read gives A=7, Nn=1, N=2. Index 1 is unchanged at 4/0/1.
- 63 updates to index 1 with inc=0, neg=0 (N reaches 64), then one with inc=2, neg=1 -> A=(4+2)>>1=3, Nn=(0+1)>>1=0, N=33.
- Read and update index 0 in the same cycle, from 4/0/1 with inc=5, neg=0 -> the read returns A=9, Nn=0, N=2.
- Drive A near max (inc=8191 repeatedly) -> A holds 8191 and does not wrap. An update with upd_idx out of range (NUM_CTX=3, idx=3) changes nothing.
- Modify both contexts, pulse clr with NUM_CTX=2 -> busy high 2 cycles; rd_en/upd_en during busy are ignored. Afterwards both entries read 4/0/1. Repeat with reset asserted mid-sweep -> busy drops immediately and entries read 4/0/1.
